// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Cascaded multi-digit BCD up/down counter. It has a synchronous parallel
// load and a combinational terminal-count output for chaining. A load
// containing any non-decimal nibble is rejected: the count holds and
// load_err pulses for one cycle.
//
// Parameters
//   DIGITS   number of BCD digits (1-8)
//   WRAP     1 = wrap past the terminal count, 0 = saturate at it
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset (count -> 0, load_err -> 0)
//   en        in   count enable
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   parallel load strobe (priority over en)
//   load_val  in   BCD value to load, digit 0 in [3:0]
//   digits    out  registered BCD count, digit 0 in [3:0]
//   tc        out  en && count at terminal (all 9s up / all 0s down)
//   load_err  out  registered one-cycle flag for a rejected load
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  tc,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      digits_q, digits_d;
    logic              load_err_q, load_err_d;

    logic [DIGITS-1:0] is_nine;
    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] nib_ok;
    // Prefix chains: entry k is true when every digit below k is 9 (or 0).
    // Entry DIGITS therefore means "whole count is all 9s / all 0s".
    logic [DIGITS:0]   nine_below;
    logic [DIGITS:0]   zero_below;
    logic [W-1:0]      stepped;
    logic              at_terminal;
    logic              load_valid;

    assign nine_below[0] = 1'b1;
    assign zero_below[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
            logic [3:0] cur_digit;
            logic [3:0] inc_digit;
            logic [3:0] dec_digit;

            assign cur_digit   = digits_q[4*gi +: 4];
            assign is_nine[gi] = (cur_digit == 4'd9);
            assign is_zero[gi] = (cur_digit == 4'd0);
            assign nib_ok[gi]  = (load_val[4*gi +: 4] <= 4'd9);

            assign nine_below[gi+1] = nine_below[gi] & is_nine[gi];
            assign zero_below[gi+1] = zero_below[gi] & is_zero[gi];

            assign inc_digit = is_nine[gi] ? 4'd0 : cur_digit + 4'd1;
            assign dec_digit = is_zero[gi] ? 4'd9 : cur_digit - 4'd1;

            // A digit only moves when all lower digits are rolling over,
            // which gives the full ripple in a single cycle.
            assign stepped[4*gi +: 4] = up ? (nine_below[gi] ? inc_digit : cur_digit)
                                           : (zero_below[gi] ? dec_digit : cur_digit);
        end
    endgenerate

    assign at_terminal = up ? nine_below[DIGITS] : zero_below[DIGITS];
    assign load_valid  = &nib_ok;

    always_comb begin
        digits_d   = digits_q;
        load_err_d = 1'b0;
        if (load) begin
            // A bad load leaves the count untouched and also suppresses
            // counting in that cycle.
            if (load_valid) begin
                digits_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (!(WRAP == 0 && at_terminal)) begin
                digits_d = stepped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q   <= '0;
            load_err_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            load_err_q <= load_err_d;
        end
    end

    assign digits   = digits_q;
    assign load_err = load_err_q;
    assign tc       = en & at_terminal;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Two 2-digit instances share all inputs: one wrapping and one saturating.
// The reference model holds each count as a plain integer 0..99 and
// converts it to BCD only for comparison.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] digits_w, digits_s;
    logic         tc_w, tc_s, err_w, err_s;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_w = 0;
    int m_s = 0;
    bit m_err = 1'b0;

    bcd_updown_counter #(.DIGITS(DIGITS), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .digits(digits_w), .tc(tc_w), .load_err(err_w)
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .digits(digits_s), .tc(tc_s), .load_err(err_s)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens, ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic int step_model(input int v, input bit dir, input bit wrap);
        if (dir) return (v == 99) ? (wrap ? 0 : 99) : v + 1;
        else     return (v == 0)  ? (wrap ? 99 : 0) : v - 1;
    endfunction

    function automatic bit exp_tc(input int v);
        return en && (up ? (v == 99) : (v == 0));
    endfunction

    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input logic [7:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
        #1;
    endtask

    // Advance one clock edge, apply the specified behaviour to the model,
    // and return 1 time unit after the edge.
    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            m_w = 0; m_s = 0; m_err = 1'b0;
        end else if (load) begin
            m_err = !bcd_ok(load_val);
            if (!m_err) begin
                m_w = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
                m_s = m_w;
            end
        end else begin
            m_err = 1'b0;
            if (en) begin
                m_w = step_model(m_w, up, 1'b1);
                m_s = step_model(m_s, up, 1'b0);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 8'h55);
        clock_edge();
        checks++; if (digits_w !== 8'h00) begin errors++; $display("FAIL reset_digits_w got %h exp 00", digits_w); end
        checks++; if (digits_s !== 8'h00) begin errors++; $display("FAIL reset_digits_s got %h exp 00", digits_s); end
        checks++; if (err_w !== 1'b0) begin errors++; $display("FAIL reset_err_w got %b exp 0", err_w); end
        // Create a pending load error, then reset must clear it.
        drive(0, 0, 1, 1, 8'hAB);
        clock_edge();
        checks++; if (err_w !== 1'b1) begin errors++; $display("FAIL reset_pre_err got %b exp 1", err_w); end
        drive(1, 0, 1, 1, 8'hCD);
        clock_edge();
        checks++; if (err_w !== 1'b0) begin errors++; $display("FAIL reset_clr_err_w got %b exp 0", err_w); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL reset_clr_err_s got %b exp 0", err_s); end
        $display("test_reset done: digits=%h err=%b", digits_w, err_w);
    endtask

    task automatic test_count_up();
        drive(1, 0, 1, 0, 8'h00);
        clock_edge();
        for (int i = 0; i < 100; i++) begin
            drive(0, 1, 1, 0, 8'h00);
            checks++; if (tc_w !== exp_tc(m_w)) begin errors++; $display("FAIL up_tc step %0d got %b exp %b", i, tc_w, exp_tc(m_w)); end
            clock_edge();
            checks++; if (digits_w !== to_bcd((i + 1) % 100)) begin errors++; $display("FAIL up_digits step %0d got %h exp %h", i, digits_w, to_bcd((i + 1) % 100)); end
        end
        $display("test_count_up done: digits=%h", digits_w);
    endtask

    task automatic test_count_down();
        drive(0, 0, 0, 1, 8'h10);
        clock_edge();
        checks++; if (digits_w !== 8'h10) begin errors++; $display("FAIL down_load got %h exp 10", digits_w); end
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 0, 0, 8'h00);
            checks++; if (tc_w !== exp_tc(m_w)) begin errors++; $display("FAIL down_tc step %0d got %b exp %b", i, tc_w, exp_tc(m_w)); end
            clock_edge();
            checks++; if (digits_w !== to_bcd(m_w)) begin errors++; $display("FAIL down_digits step %0d got %h exp %h", i, digits_w, to_bcd(m_w)); end
        end
        checks++; if (digits_w !== 8'h98) begin errors++; $display("FAIL down_final got %h exp 98", digits_w); end
        $display("test_count_down done: digits=%h", digits_w);
    endtask

    task automatic test_saturate();
        drive(0, 0, 1, 1, 8'h97);
        clock_edge();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, 8'h00);
            checks++; if (tc_s !== exp_tc(m_s)) begin errors++; $display("FAIL sat_tc step %0d got %b exp %b", i, tc_s, exp_tc(m_s)); end
            clock_edge();
            checks++; if (digits_s !== to_bcd(m_s)) begin errors++; $display("FAIL sat_digits step %0d got %h exp %h", i, digits_s, to_bcd(m_s)); end
            checks++; if (digits_w !== to_bcd(m_w)) begin errors++; $display("FAIL sat_wrap_digits step %0d got %h exp %h", i, digits_w, to_bcd(m_w)); end
        end
        checks++; if (digits_s !== 8'h99 || tc_s !== 1'b1) begin errors++; $display("FAIL sat_final got %h tc %b exp 99 tc 1", digits_s, tc_s); end
        $display("test_saturate done: sat=%h wrap=%h", digits_s, digits_w);
    endtask

    task automatic test_load_err();
        drive(0, 0, 1, 1, 8'h42);
        clock_edge();
        drive(0, 1, 1, 1, 8'h3A);
        clock_edge();
        checks++; if (digits_w !== 8'h42) begin errors++; $display("FAIL lerr_hold got %h exp 42", digits_w); end
        checks++; if (err_w !== 1'b1) begin errors++; $display("FAIL lerr_flag_w got %b exp 1", err_w); end
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL lerr_flag_s got %b exp 1", err_s); end
        drive(0, 0, 1, 0, 8'h00);
        clock_edge();
        checks++; if (err_w !== 1'b0) begin errors++; $display("FAIL lerr_pulse got %b exp 0", err_w); end
        drive(0, 1, 0, 1, 8'h55);
        clock_edge();
        checks++; if (digits_w !== 8'h55) begin errors++; $display("FAIL lerr_good_load got %h exp 55", digits_w); end
        checks++; if (err_w !== 1'b0) begin errors++; $display("FAIL lerr_good_flag got %b exp 0", err_w); end
        $display("test_load_err done: digits=%h err=%b", digits_w, err_w);
    endtask

    task automatic test_rst_load();
        drive(0, 0, 1, 1, 8'h57);
        clock_edge();
        drive(1, 1, 1, 1, 8'h11);
        clock_edge();
        checks++; if (digits_w !== 8'h00) begin errors++; $display("FAIL rstload_w got %h exp 00", digits_w); end
        checks++; if (digits_s !== 8'h00) begin errors++; $display("FAIL rstload_s got %h exp 00", digits_s); end
        drive(0, 0, 1, 0, 8'h00);
        clock_edge();
        checks++; if (digits_w !== 8'h00) begin errors++; $display("FAIL rstload_idle got %h exp 00", digits_w); end
        drive(0, 1, 1, 0, 8'h00);
        clock_edge();
        checks++; if (digits_w !== 8'h01) begin errors++; $display("FAIL rstload_resume got %h exp 01", digits_w); end
        $display("test_rst_load done: digits=%h", digits_w);
    endtask

    task automatic test_random();
        bit r, e, u, l;
        logic [7:0] lv;
        int bad = 0;
        u = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) u = ~u;
            l = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) lv = 8'($urandom);
            else                           lv = to_bcd(int'($urandom_range(0, 99)));
            drive(r, e, u, l, lv);
            checks++; if (tc_w !== exp_tc(m_w) || tc_s !== exp_tc(m_s)) begin
                errors++; bad++;
                $display("FAIL rand_tc cyc %0d got %b/%b exp %b/%b", i, tc_w, tc_s, exp_tc(m_w), exp_tc(m_s));
            end
            clock_edge();
            checks++; if (digits_w !== to_bcd(m_w) || digits_s !== to_bcd(m_s)) begin
                errors++; bad++;
                $display("FAIL rand_digits cyc %0d got %h/%h exp %h/%h", i, digits_w, digits_s, to_bcd(m_w), to_bcd(m_s));
            end
            checks++; if (err_w !== m_err || err_s !== m_err) begin
                errors++; bad++;
                $display("FAIL rand_err cyc %0d got %b/%b exp %b", i, err_w, err_s, m_err);
            end
            checks++; if (!bcd_ok(digits_w) || !bcd_ok(digits_s)) begin
                errors++; bad++;
                $display("FAIL rand_nibble cyc %0d got %h/%h exp all nibbles <= 9", i, digits_w, digits_s);
            end
        end
        $display("test_random done: 10000 cycles, %0d bad", bad);
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_err();
        test_rst_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of cascaded BCD digits (legal range 1-8).
REQ-002 The block SHALL have parameter WRAP, default 1: 1 = wrap at the terminal count, 0 = saturate at the terminal count.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset sampled on the rising clk edge.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port load_val, input, 4*DIGITS bits: BCD value to load; digit 0 in bits [3:0].
REQ-009 The block SHALL have port digits, output, 4*DIGITS bits: registered BCD count; digit 0 (least significant) in bits [3:0].
REQ-010 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag for cascading.
REQ-011 The block SHALL have port load_err, output, 1 bit: registered one-cycle flag for a rejected load.

Function
REQ-012 Priority per rising edge SHALL be rst > load > en; the count SHALL hold when none of them is asserted.
REQ-013 With en=1 and up=1, digit 0 SHALL step 0->1->...->9->0, and digit k SHALL step only when digits 0..k-1 are all 9 (BCD ripple, evaluated in a single cycle).
REQ-014 With en=1 and up=0, digit 0 SHALL step 9->8->...->0->9, and digit k SHALL step only when digits 0..k-1 are all 0.
REQ-015 The terminal value SHALL be all digits 9 when up=1, and all digits 0 when up=0.
REQ-016 tc SHALL equal en AND (digits == terminal value for the current up), combinationally, with no clock latency.
REQ-017 With WRAP=1, an enabled step from terminal SHALL go to all-0 (up) or all-9 (down).
REQ-018 With WRAP=0, an enabled step from terminal SHALL hold the value; tc SHALL remain asserted while en=1.
REQ-019 When load=1 and every nibble of load_val is <=9, digits SHALL take load_val on that edge, and en and up SHALL be ignored that cycle.
REQ-020 When load=1 and any nibble of load_val is >9, digits SHALL hold, and load_err SHALL be 1 for exactly the following cycle.
REQ-021 load_err SHALL be 0 in every cycle not covered by REQ-020.
REQ-022 A change of up mid-count SHALL take effect on the next enabled edge, with no extra state.
REQ-023 Every digit nibble SHALL always hold a value in 0-9; no sequence of inputs SHALL produce a nibble of A-F.
REQ-024 Count latency SHALL be one cycle: a value change is visible on digits immediately after the enabling edge.

Reset
REQ-025 On a rising clk edge with rst=1, digits SHALL become all 0 and load_err SHALL become 0, regardless of en, load, up and load_val.
REQ-026 rst asserted mid-count or coincident with load SHALL yield digits=0 on that edge; the load SHALL be discarded.
REQ-027 The first count step after rst deasserts SHALL occur on the first edge with rst=0 and en=1.
REQ-028 Before the first reset, outputs SHALL be unspecified; the bench SHALL apply rst for at least one edge before checking.

Verification
REQ-029 (DIGITS=2, WRAP=1) rst for 1 edge, then en=1, up=1 for 100 edges -> digits steps 00,01,...,09,10,...,99,00; tc=1 only while digits=99.
REQ-030 (DIGITS=2, WRAP=1) load 0x10, then en=1, up=0 for 12 edges -> digits 10,09,...,00,99,98; tc=1 only while digits=00.
REQ-031 (DIGITS=2, WRAP=0) load 0x97, en=1, up=1 for 5 edges -> digits 98,99,99,99,99; tc stays 1 from digits=99 onward.
REQ-032 Load 0x3A with count at 0x42 -> digits stays 0x42, load_err=1 for one cycle then 0; load 0x55 -> digits=0x55, load_err=0.
REQ-033 With en=1 and count at 0x57, assert rst and load=1 (load_val=0x11) on the same edge -> digits=0x00; count resumes 01 on the next enabled edge.
REQ-034 Random en/up/load for 10000 cycles against a reference model -> digits matches the model each cycle and no nibble ever exceeds 9.
